sclk_burst_ctrl: RTL and testbench

Sequencer for the shift-register serial clock. It turns the fast reference clock into a bounded burst of N serial-clock periods at a programmable power-of-two rate. It emits one-cycle rise/fall strobes for the shift logic and a done pulse at the end of the burst. Rate changes are accepted only between bursts, so no SCLK period is ever truncated or stretched.

---
 rtl/sclk_burst_ctrl.sv | 157 +++++++++++++++
 tb/tb_sclk_burst_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/sclk_burst_ctrl.sv
// Serial-clock burst sequencer: divides clk_in by 2**(div_cur+1) and emits a
// bounded burst of sclk periods with rise/fall/done strobes.
module sclk_burst_ctrl #(
   parameter int DIV_WIDTH = 4,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk_in,
   input  logic                 rst,
   input  logic [DIV_WIDTH-1:0] cfg_div,
   input  logic                 cfg_valid,
   output logic                 cfg_ready,
   output logic [DIV_WIDTH-1:0] div_cur,
   input  logic                 start,
   input  logic [CNT_WIDTH-1:0] nbits,
   input  logic                 abort,
   output logic                 sclk,
   output logic                 sclk_rise,
   output logic                 sclk_fall,
   output logic                 busy,
   output logic                 done,
   output logic [CNT_WIDTH-1:0] bits_left
);

   localparam int HW = (1 << DIV_WIDTH) - 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOW  = 2'd1,
      ST_HIGH = 2'd2,
      ST_FIN  = 2'd3
   } state_t;

   state_t                 state_q, state_d;
   logic [HW-1:0]          hcnt_q, hcnt_d;
   logic [DIV_WIDTH-1:0]   div_cur_q, div_cur_d;
   logic [CNT_WIDTH-1:0]   bits_left_q, bits_left_d;
   logic                   sclk_q, sclk_d;
   logic                   sclk_rise_q, sclk_rise_d;
   logic                   sclk_fall_q, sclk_fall_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   cfg_ready_q, cfg_ready_d;

   logic [HW-1:0]          h_max_s;
   logic                   half_end_s;
   logic                   last_bit_s;
   logic                   cfg_take_s;

   // H-1 as a mask of div_cur ones; the top exponent wraps to all ones.
   assign h_max_s    = ~({HW{1'b1}} << div_cur_q);
   assign half_end_s = (hcnt_q == h_max_s);
   assign last_bit_s = (bits_left_q == CNT_WIDTH'(1));
   assign cfg_take_s = cfg_valid && (state_q == ST_IDLE);

   // State register.
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; abort wins over a completing half period.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = (nbits == CNT_WIDTH'(0)) ? ST_FIN : ST_LOW;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LOW: begin
            if (abort)           state_d = ST_IDLE;
            else if (half_end_s) state_d = ST_HIGH;
            else                 state_d = ST_LOW;
         end
         ST_HIGH: begin
            if (abort)           state_d = ST_IDLE;
            else if (half_end_s) state_d = last_bit_s ? ST_IDLE : ST_LOW;
            else                 state_d = ST_HIGH;
         end
         ST_FIN:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Output decode from the upcoming state so every output is a flop.
   always_comb begin
      sclk_d      = (state_d == ST_HIGH);
      sclk_rise_d = (state_d == ST_HIGH) && (state_q != ST_HIGH);
      sclk_fall_d = (state_q == ST_HIGH) && (state_d != ST_HIGH);
      busy_d      = (state_d == ST_LOW) || (state_d == ST_HIGH);
      cfg_ready_d = (state_d == ST_IDLE);
      done_d      = (state_d == ST_FIN) ||
                    ((state_q == ST_HIGH) && (state_d == ST_IDLE) && !abort);
   end

   // Datapath: config latch, half-period counter and remaining-period count.
   always_comb begin
      div_cur_d = cfg_take_s ? cfg_div : div_cur_q;
      if ((state_d != state_q) || !((state_d == ST_LOW) || (state_d == ST_HIGH))) begin
         hcnt_d = {HW{1'b0}};
      end else begin
         hcnt_d = hcnt_q + HW'(1);
      end
      bits_left_d = bits_left_q;
      case (state_q)
         ST_IDLE: bits_left_d = start ? nbits : CNT_WIDTH'(0);
         ST_LOW:  bits_left_d = abort ? CNT_WIDTH'(0) : bits_left_q;
         ST_HIGH: begin
            if (abort)           bits_left_d = CNT_WIDTH'(0);
            else if (half_end_s) bits_left_d = bits_left_q - CNT_WIDTH'(1);
            else                 bits_left_d = bits_left_q;
         end
         ST_FIN:  bits_left_d = CNT_WIDTH'(0);
         default: bits_left_d = CNT_WIDTH'(0);
      endcase
   end

   // Output and datapath registers.
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         hcnt_q      <= {HW{1'b0}};
         div_cur_q   <= {DIV_WIDTH{1'b0}};
         bits_left_q <= {CNT_WIDTH{1'b0}};
         sclk_q      <= 1'b0;
         sclk_rise_q <= 1'b0;
         sclk_fall_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         cfg_ready_q <= 1'b1;
      end else begin
         hcnt_q      <= hcnt_d;
         div_cur_q   <= div_cur_d;
         bits_left_q <= bits_left_d;
         sclk_q      <= sclk_d;
         sclk_rise_q <= sclk_rise_d;
         sclk_fall_q <= sclk_fall_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         cfg_ready_q <= cfg_ready_d;
      end
   end

   assign cfg_ready = cfg_ready_q;
   assign div_cur   = div_cur_q;
   assign sclk      = sclk_q;
   assign sclk_rise = sclk_rise_q;
   assign sclk_fall = sclk_fall_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign bits_left = bits_left_q;

endmodule

// File: tb/tb_sclk_burst_ctrl.sv
// Bench for sclk_burst_ctrl: per-cycle comparison against a timing-formula
// model, a table of directed bursts, and randomized bursts with aborts.
module tb_sclk_burst_ctrl;

   logic        clk_in = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  cfg_div = 4'd0;
   logic        cfg_valid = 1'b0;
   logic        cfg_ready;
   logic [3:0]  div_cur;
   logic        start = 1'b0;
   logic [15:0] nbits = 16'd0;
   logic        abort = 1'b0;
   logic        sclk, sclk_rise, sclk_fall, busy, done;
   logic [15:0] bits_left;

   int total = 0;
   int bad   = 0;

   sclk_burst_ctrl #(.DIV_WIDTH(4), .CNT_WIDTH(16)) dut (
      .clk_in(clk_in), .rst(rst), .cfg_div(cfg_div), .cfg_valid(cfg_valid),
      .cfg_ready(cfg_ready), .div_cur(div_cur), .start(start), .nbits(nbits),
      .abort(abort), .sclk(sclk), .sclk_rise(sclk_rise), .sclk_fall(sclk_fall),
      .busy(busy), .done(done), .bits_left(bits_left)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      int d; int n; int a; int hold;
      int rises; int falls; int dones;
   } vec_t;

   // Field order: sclk rise fall busy done cfg_ready div[3:0] bits_left[15:0]
   function automatic logic [25:0] pack(input bit s, input bit r, input bit f, input bit b,
                                        input bit dn, input bit cr, input int dv, input int bl);
      logic [3:0]  dv4;
      logic [15:0] bl16;
      dv4  = dv[3:0];
      bl16 = bl[15:0];
      return {s, r, f, b, dn, cr, dv4, bl16};
   endfunction

   function automatic logic [25:0] actual();
      return {sclk, sclk_rise, sclk_fall, busy, done, cfg_ready, div_cur, bits_left};
   endfunction

   // Expected outputs at cycle k after a start in cycle 0 (div d, length n, abort in cycle a).
   function automatic logic [25:0] model(input int d, input int n, input int a, input int k);
      int h, t, p;
      bit edge_s, prev_hi;
      h = 1 << d;
      t = 1 + 2 * n * h;
      if (n == 0) begin
         if (k == 1) return pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, d, 0);
         return pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, d, 0);
      end
      if (a > 0 && k == a + 1) begin
         prev_hi = (((a - 1) / h) % 2) == 1;
         return pack(1'b0, 1'b0, prev_hi, 1'b0, 1'b0, 1'b1, d, 0);
      end
      if (k < t) begin
         p = (k - 1) / h;
         edge_s = (((k - 1) % h) == 0) && (k > 1);
         return pack((p % 2) == 1, edge_s && ((p % 2) == 1), edge_s && ((p % 2) == 0),
                     1'b1, 1'b0, 1'b0, d, n - (k - 1) / (2 * h));
      end
      if (k == t) return pack(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, d, 0);
      return pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, d, 0);
   endfunction

   task automatic check(input string name, input int k, input logic [25:0] exp);
      logic [25:0] act;
      act = actual();
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cycle %0d: got sclk/rise/fall/busy/done/rdy=%b div=%0d bits=%0d, want %b div=%0d bits=%0d",
                  name, k, act[25:20], act[19:16], act[15:0], exp[25:20], exp[19:16], exp[15:0]);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   // Runs one burst starting at the current negedge (DUT idle), config bypassed with start.
   task automatic run_burst(input string name, input int d, input int n, input int a, input int hold,
                            output int rises, output int falls, output int dones);
      int endc;
      rises = 0; falls = 0; dones = 0;
      endc = (n == 0) ? 1 : ((a > 0) ? a + 1 : 1 + 2 * n * (1 << d));
      cfg_div   = d[3:0];
      cfg_valid = 1'b1;
      start     = 1'b1;
      nbits     = n[15:0];
      for (int k = 1; k <= endc; k++) begin
         @(negedge clk_in);
         if (k == 1) begin
            start     = 1'b0;
            cfg_valid = 1'b0;
         end
         abort = 1'b0;
         check(name, k, model(d, n, a, k));
         rises += int'(sclk_rise);
         falls += int'(sclk_fall);
         dones += int'(done);
         if (hold >= 0 && k < endc) begin
            cfg_valid = 1'b1;
            cfg_div   = hold[3:0];
         end
         if (a > 0 && k == a) abort = 1'b1;
      end
      if (n == 0) begin
         @(negedge clk_in);
         check(name, 2, model(d, n, a, 2));
      end
      if (hold >= 0) begin
         @(negedge clk_in);
         cfg_valid = 1'b0;
         check_int({name, "_div_after"}, int'(div_cur), hold);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[8];
      int r, f, dn, bound;
      tbl[0] = '{d:0, n:3, a:0,  hold:-1, rises:3, falls:3, dones:1};
      tbl[1] = '{d:2, n:1, a:0,  hold:-1, rises:1, falls:1, dones:1};
      tbl[2] = '{d:0, n:2, a:0,  hold:3,  rises:2, falls:2, dones:1};
      tbl[3] = '{d:0, n:0, a:0,  hold:-1, rises:0, falls:0, dones:1};
      tbl[4] = '{d:1, n:5, a:11, hold:-1, rises:3, falls:3, dones:0};
      tbl[5] = '{d:0, n:1, a:1,  hold:-1, rises:0, falls:0, dones:0};
      tbl[6] = '{d:0, n:2, a:4,  hold:-1, rises:2, falls:2, dones:0};
      tbl[7] = '{d:1, n:2, a:0,  hold:-1, rises:2, falls:2, dones:1};

      repeat (3) @(negedge clk_in);
      check("reset", 0, pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0));
      rst = 1'b0;
      @(negedge clk_in);
      check("idle", 0, pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0));

      for (int i = 0; i < 8; i++) begin
         run_burst($sformatf("tbl%0d", i), tbl[i].d, tbl[i].n, tbl[i].a, tbl[i].hold, r, f, dn);
         check_int($sformatf("tbl%0d_rises", i), r, tbl[i].rises);
         check_int($sformatf("tbl%0d_falls", i), f, tbl[i].falls);
         check_int($sformatf("tbl%0d_dones", i), dn, tbl[i].dones);
      end

      // Asynchronous reset while sclk is high.
      cfg_div = 4'd2; cfg_valid = 1'b1; start = 1'b1; nbits = 16'd2;
      @(negedge clk_in);
      start = 1'b0; cfg_valid = 1'b0;
      bound = 0;
      while (sclk !== 1'b1 && bound < 100) begin
         @(negedge clk_in);
         bound++;
      end
      check_int("rst_wait_sclk", int'(sclk === 1'b1), 1);
      #2;
      rst = 1'b1;
      #1;
      check("rst_mid", 0, pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0));
      @(negedge clk_in);
      rst = 1'b0;
      @(negedge clk_in);
      check("rst_release", 0, pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0));
      run_burst("after_rst", 1, 3, 0, -1, r, f, dn);
      check_int("after_rst_dones", dn, 1);

      for (int i = 0; i < 40; i++) begin
         int d, n, a;
         d = $urandom_range(0, 3);
         n = $urandom_range(0, 4);
         a = 0;
         if (n > 0 && $urandom_range(0, 3) == 0) a = $urandom_range(1, 2 * n * (1 << d));
         run_burst($sformatf("rnd%0d", i), d, n, a, -1, r, f, dn);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
